// File: rtl/dm_readback.sv
// Sequential DataMem reader: walks a word range through the MemRead port and streams
// each word with its index. Optional running checksum output under DM_READBACK_CSUM_EN.
module dm_readback #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CW     = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_count,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] out_index
`ifdef DM_READBACK_CSUM_EN
    ,
    output logic [DW-1:0] csum
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] issue_q, issue_d;
    logic [CW-1:0] ret_q, ret_d;
    logic [AW-1:0] addr_hold_q;
    logic          busy_q, done_q;

    logic [DW-1:0] fifo_data_q [2];
    logic [CW-1:0] fifo_idx_q  [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fifo_cnt_q;

    logic          outst_w;
    logic          push, pop, last_pop;
    logic [2:0]    inflight;
    logic [AW-1:0] issue_addr;

    // Words already requested but not yet handed off: the FIFO plus any read in flight.
    assign inflight   = {1'b0, fifo_cnt_q} + {2'b00, outst_w};
    assign issue_addr = base_q + {{(AW-CW-2){1'b0}}, issue_q, 2'b00};
    assign mem_rd     = (state_q == S_RUN) && !abort && (issue_q != count_q) && (inflight < 3'd2);
    assign mem_addr   = mem_rd ? issue_addr : addr_hold_q;

    assign out_valid  = (fifo_cnt_q != 2'd0);
    assign out_data   = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_index  = out_valid ? fifo_idx_q[rd_ptr_q] : '0;
    assign pop        = out_valid && out_ready;
    assign last_pop   = pop && (fifo_idx_q[rd_ptr_q] == count_q - 1'b1);

    assign busy = busy_q;
    assign done = done_q;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign outst_w = 1'b0;
            assign push    = mem_rd;
        end else begin : g_lat1
            logic outst_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) outst_q <= 1'b0;
                else        outst_q <= mem_rd;
            end
            assign outst_w = outst_q;
            assign push    = outst_q && !abort;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        issue_d = mem_rd ? issue_q + 1'b1 : issue_q;
        ret_d   = push ? ret_q + 1'b1 : ret_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        base_d  = {base_addr[AW-1:2], 2'b00};
                        count_d = word_count;
                        issue_d = '0;
                        ret_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN:   if (issue_d == count_q) state_d = S_DRAIN;
            S_DRAIN: if (last_pop) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issue_q     <= '0;
            ret_q       <= '0;
            addr_hold_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
            if (mem_rd) addr_hold_q <= issue_addr;
            busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Occupancy and pointers reset; storage does not need to since reads are gated by out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else if (abort) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_idx_q[wr_ptr_q]  <= ret_q;
        end
    end

`ifdef DM_READBACK_CSUM_EN
    logic [DW-1:0] csum_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 csum_q <= '0;
        else if (abort || (state_q == S_IDLE && start)) csum_q <= '0;
        else if (pop)                               csum_q <= csum_q + out_data;
    end
    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_dm_readback.sv
// Directed bench for dm_readback: a word-level model of the expected read/stream sequence
// is checked every cycle, plus literal expectations from hand-computed vectors.
module tb_dm_readback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [9:0]  word_count;
    logic        abort;
    logic        busy, done, mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_index;
`ifdef DM_READBACK_CSUM_EN
    logic [31:0] csum;
`endif

    dm_readback #(.AW(32), .DW(32), .CW(10), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index)
`ifdef DM_READBACK_CSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    // DataMem with one-cycle registered read
    logic [31:0] dm [1024];
    always @(posedge clk) if (mem_rd) mem_rdata <= dm[mem_addr[11:2]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int want);
        total++;
        bad++;
        $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    // Model state for the current run
    logic [31:0] exp_addr [64];
    logic [31:0] exp_data [64];
    logic [31:0] rd_log   [64];
    int          n_exp = 0, issued = 0, handed = 0, done_cnt = 0;
    int          cyc = 0, start_cyc = 0, first_rd = -1, first_v = -1;
    bit          check_en = 0, want_done = 0, prev_stall = 0;
    logic [31:0] prev_data, first_data, last_data, model_sum;
    logic [9:0]  prev_idx;

    always @(negedge clk) begin
        cyc++;
        if (!check_en || !rst_n) begin
            prev_stall = 0;
        end else begin
            if (mem_rd) begin
                if (first_rd < 0) first_rd = cyc;
                if (issued < n_exp) begin
                    chk("rd_addr", mem_addr, exp_addr[issued]);
                    rd_log[issued] = mem_addr;
                end else fail_now("rd_extra", issued, n_exp);
                chk("rd_inflight_lt2", (issued - handed) < 2, 1);
                issued++;
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_index", out_index, prev_idx);
            end
            if (out_valid && first_v < 0) first_v = cyc;
            chk("done", done, want_done);
            if (done) done_cnt++;
            want_done = 0;
            if (out_valid && out_ready) begin
                if (handed < n_exp) begin
                    chk("beat_index", out_index, handed[9:0]);
                    chk("beat_data", out_data, exp_data[handed]);
                end else fail_now("beat_extra", handed, n_exp);
                if (handed == 0) first_data = out_data;
                last_data = out_data;
                model_sum = model_sum + out_data;
                handed++;
                if (handed == n_exp && !abort) want_done = 1;
            end
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
            prev_idx   = out_index;
        end
    end

    // out_ready driver: level or the 1,0,0,1 backpressure pattern
    bit       bp_mode = 0;
    int       phase = 0;
    bit [3:0] bp_pat = 4'b1001;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = bp_pat[3 - phase];
                phase = (phase + 1) % 4;
            end else out_ready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_index"}, out_index, 0);
    endtask

    task automatic run(input logic [31:0] base, input int n, input int stop_after, input bit use_rst);
        logic [31:0] a;
        bit finished;
        for (int i = 0; i < n; i++) begin
            a = {base[31:2], 2'b00} + 32'(4 * i);
            exp_addr[i] = a;
            exp_data[i] = dm[a[11:2]];
        end
        n_exp = n; issued = 0; handed = 0; done_cnt = 0;
        first_rd = -1; first_v = -1; want_done = 0; model_sum = '0; prev_stall = 0;
        check_en = 1;
        base_addr = base; word_count = n[9:0]; start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        if (n == 0) want_done = 1;
        chk("busy_after_start", busy, (n != 0));
        finished = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            if (done_cnt > 0) finished = 1;
            else if (stop_after > 0 && handed >= stop_after) begin
                if (use_rst) begin
                    check_en = 0;
                    rst_n = 1'b0;
                    #1;
                    check_outputs_zero("async_rst");
                    tick();
                    rst_n = 1'b1;
                    tick();
                end else begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_busy", busy, 0);
                    chk("abort_out_valid", out_valid, 0);
                    chk("abort_mem_rd", mem_rd, 0);
`ifdef DM_READBACK_CSUM_EN
                    chk("abort_csum", csum, 0);
`endif
                    repeat (4) tick();
                    chk("abort_no_done", done_cnt, 0);
                end
                finished = 1;
            end else tick();
        end
        if (!finished) fail_now("timeout", handed, n);
        if (stop_after == 0) begin
            chk("beats_total", handed, n);
            chk("reads_total", issued, n);
            chk("done_once", done_cnt, 1);
`ifdef DM_READBACK_CSUM_EN
            chk("csum_model", csum, model_sum);
`endif
            tick();
            chk("busy_after_done", busy, 0);
        end
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        for (int i = 0; i < 1024; i++) dm[i] = 32'hA500_0000 | 32'(i);
        for (int i = 0; i < 20; i++) dm[250 + i] = 32'h100 + 32'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        base_addr = '0; word_count = '0;
        #12;
        check_outputs_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Basic run
        run(32'h3E8, 20, 0, 0);
        chk("lat_first_rd", first_rd - start_cyc, 1);
        chk("lat_first_valid", first_v - start_cyc, 3);
        chk("basic_first_data", first_data, 32'h100);
        chk("basic_last_data", last_data, 32'h113);
        chk("basic_first_addr", rd_log[0], 32'h3E8);
        chk("basic_last_addr", rd_log[19], 32'h434);
`ifdef DM_READBACK_CSUM_EN
        chk("basic_csum", csum, 32'h14BE);
`endif

        // Backpressure
        bp_mode = 1; phase = 0;
        run(32'h3E8, 20, 0, 0);
        bp_mode = 0;
        repeat (2) tick();

        // Zero count
        run(32'h3E8, 0, 0, 0);
        chk("zero_no_read", issued, 0);
        chk("zero_no_beat", handed, 0);

        // Address wrap
        run(32'hFFFF_FFF8, 4, 0, 0);
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000; wrap_exp[3] = 32'h0000_0004;
        for (int i = 0; i < 4; i++) chk("wrap_addr", rd_log[i], wrap_exp[i]);

        // Abort after 5 words, then a clean run
        run(32'h3E8, 20, 5, 0);
        run(32'h3E8, 20, 0, 0);
        chk("post_abort_first", first_data, 32'h100);

        // Reset mid-run, then a clean run
        run(32'h3E8, 20, 5, 1);
        run(32'h3E8, 20, 0, 0);
        chk("post_rst_first", first_data, 32'h100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
